// File: rtl/cam_ctrl_pkg.sv
// Shared state encoding and constants for the CAM fill controller.
package cam_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      COMPARE,
      FETCH,
      FILL,
      RESP
   } cam_ctrl_state_t;

   localparam int STAT_W = 16;

endpackage

// File: rtl/cam_victim_ptr.sv
// Round-robin CAM victim slot pointer, counts modulo WORDS on each advance.
module cam_victim_ptr
   import cam_ctrl_pkg::*;
#(
   parameter int WORDS     = 8,
   parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               advance,
   output logic [ADDR_LEFT:0] ptr
);

   localparam int PW = ADDR_LEFT + 1;
   localparam logic [ADDR_LEFT:0] LAST = PW'(WORDS - 1);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
      end
   end

endmodule

// File: rtl/cam_fill_ctrl.sv
// Lookup/miss-fill sequencer in front of a tag-matched CAM.
// Optional hit/miss counters are enabled by defining CAM_FILL_CTRL_STATS_EN.
module cam_fill_ctrl
   import cam_ctrl_pkg::*;
#(
   parameter int WORDS     = 8,
   parameter int BITS      = 8,
   parameter int ADDR_LEFT = $clog2(WORDS) - 1,
   parameter int TAG_SZ    = 8
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               req,
   input  logic [TAG_SZ-1:0]  req_tag,
   output logic               ready,
   output logic               rsp_valid,
   output logic               rsp_hit,
   output logic [BITS-1:0]    rsp_data,
   output logic               cam_read,
   output logic [TAG_SZ-1:0]  cam_check_tag,
   input  logic               cam_found,
   input  logic [BITS-1:0]    cam_data,
   output logic               cam_write_,
   output logic [ADDR_LEFT:0] cam_w_addr,
   output logic [BITS-1:0]    cam_wdata,
   output logic [TAG_SZ-1:0]  cam_new_tag,
   output logic               cam_new_valid,
   output logic               mem_req,
   output logic [TAG_SZ-1:0]  mem_tag,
   input  logic               mem_ack,
   input  logic [BITS-1:0]    mem_rdata
`ifdef CAM_FILL_CTRL_STATS_EN
   ,
   output logic [STAT_W-1:0]  hit_cnt,
   output logic [STAT_W-1:0]  miss_cnt
`endif
);

   cam_ctrl_state_t    state, next_state;
   logic [TAG_SZ-1:0]  tag_q;
   logic [BITS-1:0]    fill_q;
   logic [ADDR_LEFT:0] victim;
   logic               advance;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (req) next_state = LOOKUP;
         LOOKUP:  next_state = COMPARE;
         COMPARE: next_state = cam_found ? RESP : FETCH;
         FETCH:   if (mem_ack) next_state = FILL;
         FILL:    next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Strobes are pure state decodes so no input reaches an output combinationally.
   always_comb begin
      ready         = 1'b0;
      cam_read      = 1'b0;
      cam_write_    = 1'b1;
      cam_new_valid = 1'b0;
      mem_req       = 1'b0;
      rsp_valid     = 1'b0;
      advance       = 1'b0;
      case (state)
         IDLE:   ready = 1'b1;
         LOOKUP: cam_read = 1'b1;
         FETCH:  mem_req = 1'b1;
         FILL: begin
            cam_write_    = 1'b0;
            cam_new_valid = 1'b1;
            advance       = 1'b1;
         end
         RESP:   rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         tag_q    <= '0;
         fill_q   <= '0;
         rsp_data <= '0;
         rsp_hit  <= 1'b0;
      end else begin
         if (state == IDLE && req) tag_q <= req_tag;
         if (state == COMPARE && cam_found) begin
            rsp_data <= cam_data;
            rsp_hit  <= 1'b1;
         end
         if (state == FETCH && mem_ack) fill_q <= mem_rdata;
         if (state == FILL) begin
            rsp_data <= fill_q;
            rsp_hit  <= 1'b0;
         end
      end
   end

   cam_victim_ptr #(
      .WORDS     (WORDS),
      .ADDR_LEFT (ADDR_LEFT)
   ) u_victim (
      .clk     (clk),
      .rst_    (rst_),
      .advance (advance),
      .ptr     (victim)
   );

   assign cam_check_tag = tag_q;
   assign mem_tag       = tag_q;
   assign cam_new_tag   = tag_q;
   assign cam_wdata     = fill_q;
   assign cam_w_addr    = victim;

`ifdef CAM_FILL_CTRL_STATS_EN
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state == COMPARE) begin
         if (cam_found && hit_cnt != '1)   hit_cnt  <= hit_cnt + STAT_W'(1);
         if (!cam_found && miss_cnt != '1) miss_cnt <= miss_cnt + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Directed bench for cam_fill_ctrl with a behavioural CAM and backing memory.
module tb_cam_fill_ctrl;

   localparam int WORDS  = 8;
   localparam int BITS   = 8;
   localparam int TAG_SZ = 8;
   localparam int AW     = 3;

   logic              clk = 1'b0;
   logic              rst_;
   logic              req;
   logic [TAG_SZ-1:0] req_tag;
   logic              ready, rsp_valid, rsp_hit;
   logic [BITS-1:0]   rsp_data;
   logic              cam_read;
   logic [TAG_SZ-1:0] cam_check_tag;
   logic              cam_found = 1'b0;
   logic [BITS-1:0]   cam_data = '0;
   logic              cam_write_;
   logic [AW-1:0]     cam_w_addr;
   logic [BITS-1:0]   cam_wdata;
   logic [TAG_SZ-1:0] cam_new_tag;
   logic              cam_new_valid;
   logic              mem_req;
   logic [TAG_SZ-1:0] mem_tag;
   logic              mem_ack;
   logic [BITS-1:0]   mem_rdata;
`ifdef CAM_FILL_CTRL_STATS_EN
   logic [15:0]       hit_cnt, miss_cnt;
`endif

   always #5 clk = ~clk;

   cam_fill_ctrl #(
      .WORDS  (WORDS),
      .BITS   (BITS),
      .TAG_SZ (TAG_SZ)
   ) dut (
      .clk           (clk),
      .rst_          (rst_),
      .req           (req),
      .req_tag       (req_tag),
      .ready         (ready),
      .rsp_valid     (rsp_valid),
      .rsp_hit       (rsp_hit),
      .rsp_data      (rsp_data),
      .cam_read      (cam_read),
      .cam_check_tag (cam_check_tag),
      .cam_found     (cam_found),
      .cam_data      (cam_data),
      .cam_write_    (cam_write_),
      .cam_w_addr    (cam_w_addr),
      .cam_wdata     (cam_wdata),
      .cam_new_tag   (cam_new_tag),
      .cam_new_valid (cam_new_valid),
      .mem_req       (mem_req),
      .mem_tag       (mem_tag),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata)
`ifdef CAM_FILL_CTRL_STATS_EN
      ,
      .hit_cnt       (hit_cnt),
      .miss_cnt      (miss_cnt)
`endif
   );

   // CAM model: registered lookup, write on active-low strobe; not cleared by rst_.
   logic [TAG_SZ-1:0] ctag [WORDS] = '{default: '0};
   logic              cval [WORDS] = '{default: 1'b0};
   logic [BITS-1:0]   cdat [WORDS] = '{default: '0};
   int                wr_count = 0;

   always @(posedge clk) begin
      if (cam_read) begin
         cam_found <= 1'b0;
         cam_data  <= '0;
         for (int i = 0; i < WORDS; i++)
            if (cval[i] && ctag[i] == cam_check_tag) begin
               cam_found <= 1'b1;
               cam_data  <= cdat[i];
            end
      end
      if (!cam_write_) begin
         ctag[cam_w_addr] <= cam_new_tag;
         cval[cam_w_addr] <= cam_new_valid;
         cdat[cam_w_addr] <= cam_wdata;
         wr_count         <= wr_count + 1;
      end
   end

   // Memory model: ack after ack_delay waiting cycles; data = tag ^ 8'h99.
   int   ack_delay = 3;
   int   wait_cnt  = 0;
   logic stray_ack = 1'b0;

   always @(posedge clk) begin
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
   end

   assign mem_ack   = (mem_req && wait_cnt == ack_delay) || stray_ack;
   assign mem_rdata = mem_tag ^ 8'h99;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit          hit;
      logic [7:0]  data;
      int          rsp_k, ack_k, wr_k, nwr;
      logic [AW-1:0] waddr;
      logic [7:0]  wtag, wdat;
      bit          mem_seen;
      bit          busy_ready;
   } res_t;

   task automatic do_req(input logic [7:0] tag, input bit busy_pulse, output res_t r);
      int k, busy_chk;
      bit done, busy_done;
      r = '{hit: 0, data: 0, rsp_k: -1, ack_k: -1, wr_k: -1, nwr: 0, waddr: 0,
            wtag: 0, wdat: 0, mem_seen: 0, busy_ready: 1};
      busy_chk  = -1;
      busy_done = 0;
      @(negedge clk);
      for (int w = 0; w < 50 && !ready; w++) @(negedge clk);
      req     = 1'b1;
      req_tag = tag;
      k       = 0;
      done    = 0;
      while (!done && k < 200) begin
         @(negedge clk);
         k++;
         if (k == 1) req = 1'b0;
         if (mem_req) begin
            r.mem_seen = 1;
            if (mem_ack && r.ack_k < 0) r.ack_k = k;
            if (busy_pulse && !busy_done) begin
               req       = 1'b1;
               req_tag   = 8'h77;
               busy_done = 1;
               busy_chk  = k + 1;
            end
         end
         if (k == busy_chk) begin
            r.busy_ready = ready;
            req = 1'b0;
         end
         if (!cam_write_) begin
            r.nwr++;
            r.wr_k  = k;
            r.waddr = cam_w_addr;
            r.wtag  = cam_new_tag;
            r.wdat  = cam_wdata;
         end
         if (rsp_valid) begin
            done   = 1;
            r.rsp_k = k;
            r.hit  = rsp_hit;
            r.data = rsp_data;
         end
      end
      req = 1'b0;
      if (!done) check("rsp_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_ = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      res_t r;
      int   wr0;
      rst_    = 1'b0;
      req     = 1'b0;
      req_tag = '0;
      repeat (2) @(negedge clk);
      check("rst_ready",     ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_hit",   rsp_hit, 0);
      check("rst_rsp_data",  rsp_data, 0);
      check("rst_cam_read",  cam_read, 0);
      check("rst_cam_write", cam_write_, 1);
      check("rst_mem_req",   mem_req, 0);
      check("rst_w_addr",    cam_w_addr, 0);
      check("rst_tag",       cam_check_tag, 0);
      check("rst_new_valid", cam_new_valid, 0);
      rst_ = 1'b1;
      @(negedge clk);

      // Stray ack while idle must not disturb anything
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      check("stray_ready",   ready, 1);
      check("stray_mem_req", mem_req, 0);
      @(negedge clk);
      check("stray_ready2",  ready, 1);
      check("stray_write",   wr_count, 0);

      // Cold miss
      ack_delay = 3;
      do_req(8'h3C, 0, r);
      check("cold_hit",   r.hit, 0);
      check("cold_data",  r.data, 8'hA5);
      check("cold_nwr",   r.nwr, 1);
      check("cold_waddr", r.waddr, 0);
      check("cold_wtag",  r.wtag, 8'h3C);
      check("cold_wdat",  r.wdat, 8'hA5);
      check("cold_wr_k",  r.wr_k, 7);
      check("cold_rsp_k", r.rsp_k, 8);
      check("cold_ack2rsp", r.rsp_k - r.ack_k, 2);

      // Hit after fill
      do_req(8'h3C, 0, r);
      check("hit_hit",   r.hit, 1);
      check("hit_data",  r.data, 8'hA5);
      check("hit_rsp_k", r.rsp_k, 3);
      check("hit_mem",   r.mem_seen, 0);
      check("hit_nwr",   r.nwr, 0);

      // Victim wrap after reset: tags 00..08 fill slots 0..7 then 0
      do_reset();
      ack_delay = 1;
      for (int t = 0; t < 9; t++) begin
         do_req(8'(t), 0, r);
         check("wrap_hit",   r.hit, 0);
         check("wrap_waddr", r.waddr, 32'(t % 8));
         check("wrap_data",  r.data, 32'(t ^ 8'h99));
         check("wrap_rsp_k", r.rsp_k, 6);
      end
      do_req(8'h00, 0, r);
      check("evict_hit",   r.hit, 0);
      check("evict_waddr", r.waddr, 1);
      do_req(8'h08, 0, r);
      check("wrap8_hit",  r.hit, 1);
      check("wrap8_data", r.data, 8'h91);

      // Zero-wait ack
      ack_delay = 0;
      do_req(8'h20, 0, r);
      check("zw_ack_k", r.ack_k, 3);
      check("zw_wr_k",  r.wr_k, 4);
      check("zw_rsp_k", r.rsp_k, 5);
      check("zw_waddr", r.waddr, 2);
      check("zw_data",  r.data, 8'hB9);

      // Busy request during FETCH is ignored
      ack_delay = 4;
      do_req(8'h50, 1, r);
      check("busy_ready", r.busy_ready, 0);
      check("busy_wtag",  r.wtag, 8'h50);
      check("busy_data",  r.data, 8'hC9);
      check("busy_rsp_k", r.rsp_k, 9);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("busy_idle_ready", ready, 1);
         check("busy_idle_read",  cam_read, 0);
      end
`ifdef CAM_FILL_CTRL_STATS_EN
      check("hit_cnt",  hit_cnt, 1);
      check("miss_cnt", miss_cnt, 12);
`endif

      // Reset mid-fetch
      ack_delay = 50;
      @(negedge clk);
      req     = 1'b1;
      req_tag = 8'h40;
      @(negedge clk);
      req = 1'b0;
      for (int w = 0; w < 20 && !mem_req; w++) @(negedge clk);
      check("mf_fetch", mem_req, 1);
      @(negedge clk);
      wr0  = wr_count;
      rst_ = 1'b0;
      #1;
      check("mf_mem_req", mem_req, 0);
      check("mf_ready",   ready, 1);
      check("mf_write",   cam_write_, 1);
      @(negedge clk);
      @(negedge clk);
      rst_ = 1'b1;
      @(negedge clk);
      check("mf_no_write", wr_count - wr0, 0);
`ifdef CAM_FILL_CTRL_STATS_EN
      check("mf_hit_cnt",  hit_cnt, 0);
      check("mf_miss_cnt", miss_cnt, 0);
`endif
      ack_delay = 2;
      do_req(8'h41, 0, r);
      check("mf_next_waddr", r.waddr, 0);
      check("mf_next_data",  r.data, 8'hD8);
      check("mf_next_rsp_k", r.rsp_k, 7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
